dice_guess_entry: RTL and testbench



---
 rtl/dice_guess_entry_pkg.sv | 32 +++
 rtl/dice_guess_entry_debounce.sv | 58 +++++
 rtl/dice_guess_entry.sv | 98 +++++++++
 tb/tb_dice_guess_entry.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dice_guess_entry_pkg.sv
// Shared definitions for the dice guess entry block.
//  - state_t   : FSM state codes (2-bit; the spare codes recover to ST_EDIT)
//  - DICE_MIN / DICE_MAX : legal guess range defaults
//  - DEFAULT_DEBOUNCE_CYCLES / DEFAULT_CNT_W : 10 ms at 50 MHz
//  - wrap_inc / wrap_dec : range-limited step with wrap-around
package dice_guess_entry_pkg;

    typedef enum logic [1:0] {
        ST_EDIT = 2'b00,
        ST_HOLD = 2'b01
    } state_t;

    localparam int DICE_MIN                = 2;
    localparam int DICE_MAX                = 12;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 20;

    // Compare against the range bounds before stepping, so a 4-bit
    // overflow or underflow can never produce an out-of-range guess.
    function automatic logic [3:0] wrap_inc(input logic [3:0] v,
                                            input logic [3:0] lo,
                                            input logic [3:0] hi);
        return (v >= hi) ? lo : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] v,
                                            input logic [3:0] lo,
                                            input logic [3:0] hi);
        return (v <= lo) ? hi : v - 4'd1;
    endfunction

endpackage

// File: rtl/dice_guess_entry_debounce.sv
// btn_debounce: synchronizes and debounces one raw active-low push button.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  btn_n      : raw button, asynchronous, 0 = pressed
//  level      : debounced button level (1 = released)
//  press      : one-cycle pulse on each released->pressed debounced transition
module btn_debounce
    import dice_guess_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here uses non-blocking assignment so each stage samples
    // the value its predecessor held before the edge; blocking would collapse
    // the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            level_d <= level;
            // Registered edge detect: only a 1->0 debounced transition pulses.
            press   <= level_d & ~level;

            // Any sample agreeing with the accepted level restarts the count,
            // so a glitch shorter than DEBOUNCE_CYCLES never gets through.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dice_guess_entry.sv
// dice_guess_entry: player-input front end for the dice game.
// Debounces up/down/enter buttons, edits a guess within MIN_VAL..MAX_VAL
// with wrap-around, and offers the committed guess over a valid/ack handshake.
// Ports:
//  clk, rst_n   : clock, asynchronous active-low reset
//  btn_up_n     : raw up button, 0 = pressed
//  btn_down_n   : raw down button, 0 = pressed
//  btn_enter_n  : raw enter button, 0 = pressed
//  value_ack    : game control consumed the committed value (level)
//  value        : current guess
//  value_valid  : committed guess held stable on value
//  editing      : high while editing (drives display blink)
module dice_guess_entry
    import dice_guess_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int MIN_VAL         = DICE_MIN,
    parameter int MAX_VAL         = DICE_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_enter_n,
    input  logic       value_ack,
    output logic [3:0] value,
    output logic       value_valid,
    output logic       editing
);

    localparam logic [3:0] LO = 4'(MIN_VAL);
    localparam logic [3:0] HI = 4'(MAX_VAL);

    logic   up_level, down_level, enter_level;
    logic   up_press, down_press, enter_press;
    state_t state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_up_n),
        .level(up_level), .press(up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_down_n),
        .level(down_level), .press(down_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_enter_n),
        .level(enter_level), .press(enter_press)
    );

    // The FSM acts on press events only; the debounced levels are kept on
    // the debouncer interface for other users.
    logic unused_levels;
    assign unused_levels = ^{up_level, down_level, enter_level};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EDIT;
            value       <= LO;
            value_valid <= 1'b0;
            editing     <= 1'b1;
        end else begin
            case (state)
                ST_EDIT: begin
                    // Enter takes priority and freezes the value as it is.
                    if (enter_press) begin
                        state       <= ST_HOLD;
                        value_valid <= 1'b1;
                        editing     <= 1'b0;
                    end else if (up_press && !down_press) begin
                        value <= wrap_inc(value, LO, HI);
                    end else if (down_press && !up_press) begin
                        value <= wrap_dec(value, LO, HI);
                    end
                end
                ST_HOLD: begin
                    // Button events here are simply dropped, not queued.
                    if (value_ack) begin
                        state       <= ST_EDIT;
                        value_valid <= 1'b0;
                        editing     <= 1'b1;
                    end
                end
                // NOTE: the spare encodings fall back to EDIT with outputs
                // consistent with it, so an upset state cannot lock up.
                default: begin
                    state       <= ST_EDIT;
                    value_valid <= 1'b0;
                    editing     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_guess_entry.sv
// Directed self-checking bench for dice_guess_entry, run with
// DEBOUNCE_CYCLES=4, CNT_W=3, range 2..12. Outputs are sampled on the
// falling clock edge; inputs change right after a falling edge.
module tb_dice_guess_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up_n, btn_down_n, btn_enter_n;
    logic       value_ack;
    logic [3:0] value;
    logic       value_valid;
    logic       editing;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    dice_guess_entry #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .MIN_VAL(2),
        .MAX_VAL(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up_n(btn_up_n),
        .btn_down_n(btn_down_n),
        .btn_enter_n(btn_enter_n),
        .value_ack(value_ack),
        .value(value),
        .value_valid(value_valid),
        .editing(editing)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask = {enter, down, up}; hold low for 'hold' clocks, then release
    // and let the release debounce settle.
    task automatic press_btns(input logic [2:0] mask, input int hold);
        @(negedge clk);
        if (mask[0]) btn_up_n    = 1'b0;
        if (mask[1]) btn_down_n  = 1'b0;
        if (mask[2]) btn_enter_n = 1'b0;
        negs(hold);
        btn_up_n    = 1'b1;
        btn_down_n  = 1'b1;
        btn_enter_n = 1'b1;
        negs(10);
    endtask

    task automatic check_state(input string tag, input logic [3:0] v,
                               input logic vld, input logic ed);
        check({tag, "_value"}, 8'(value), 8'(v));
        check({tag, "_valid"}, 8'(value_valid), 8'(vld));
        check({tag, "_editing"}, 8'(editing), 8'(ed));
    endtask

    initial begin
        rst_n       = 1'b0;
        btn_up_n    = 1'b1;
        btn_down_n  = 1'b1;
        btn_enter_n = 1'b1;
        value_ack   = 1'b0;
        negs(3);
        check_state("reset", 4'd2, 1'b0, 1'b1);
        rst_n = 1'b1;
        negs(2);

        // Single up press: pulse 6 clocks after the sampling edge, value next edge.
        @(negedge clk);
        btn_up_n = 1'b0;
        negs(6);
        check("up_press_early", 8'(dut.u_up.press), 8'd0);
        check("up_value_early", 8'(value), 8'd2);
        negs(1);
        check("up_press_pulse", 8'(dut.u_up.press), 8'd1);
        check("up_value_before", 8'(value), 8'd2);
        negs(1);
        check("up_press_single", 8'(dut.u_up.press), 8'd0);
        check("up_value_after", 8'(value), 8'd3);
        negs(22);
        check("up_held_no_repeat", 8'(value), 8'd3);
        btn_up_n = 1'b1;
        negs(10);
        check("up_release_no_event", 8'(value), 8'd3);

        // Wrap-around both ways.
        press_btns(3'b010, 10);
        check("down_to_min", 8'(value), 8'd2);
        for (int i = 0; i < 10; i++) press_btns(3'b001, 10);
        check("up_to_max", 8'(value), 8'd12);
        press_btns(3'b001, 10);
        check("wrap_max_to_min", 8'(value), 8'd2);
        press_btns(3'b010, 10);
        check("wrap_min_to_max", 8'(value), 8'd12);
        for (int i = 0; i < 5; i++) press_btns(3'b010, 10);
        check("down_to_7", 8'(value), 8'd7);

        // Bounce: 3-clock lows separated by 1-clock highs never qualify.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            btn_up_n = 1'b0;
            negs(3);
            btn_up_n = 1'b1;
            negs(1);
        end
        negs(10);
        check("bounce_level", 8'(dut.u_up.level), 8'd1);
        check("bounce_value", 8'(value), 8'd7);

        // Handshake: commit 7, ignore edits in HOLD, release on ack.
        press_btns(3'b100, 10);
        check_state("enter", 4'd7, 1'b1, 1'b0);
        press_btns(3'b001, 10);
        press_btns(3'b010, 10);
        press_btns(3'b100, 10);
        check_state("hold_frozen", 4'd7, 1'b1, 1'b0);
        @(negedge clk);
        value_ack = 1'b1;
        negs(1);
        value_ack = 1'b0;
        check_state("ack", 4'd7, 1'b0, 1'b1);
        negs(10);
        check_state("ack_no_queue", 4'd7, 1'b0, 1'b1);
        @(negedge clk);
        value_ack = 1'b1;
        negs(2);
        value_ack = 1'b0;
        check_state("ack_in_edit", 4'd7, 1'b0, 1'b1);

        // Simultaneous events.
        press_btns(3'b101, 10);
        check_state("enter_up_same", 4'd7, 1'b1, 1'b0);
        @(negedge clk);
        value_ack = 1'b1;
        negs(1);
        value_ack = 1'b0;
        press_btns(3'b011, 10);
        check_state("up_down_same", 4'd7, 1'b0, 1'b1);
        press_btns(3'b001, 10);
        check("up_after_same", 8'(value), 8'd8);

        // Asynchronous reset while in HOLD, with up held through reset.
        press_btns(3'b100, 10);
        check_state("hold_before_reset", 4'd8, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_state("async_reset", 4'd2, 1'b0, 1'b1);
        btn_up_n = 1'b0;
        negs(3);
        rst_n = 1'b1;
        negs(7);
        check("held_thru_reset_before", 8'(value), 8'd2);
        negs(1);
        check("held_thru_reset_after", 8'(value), 8'd3);
        negs(20);
        btn_up_n = 1'b1;
        negs(10);
        check("held_thru_reset_once", 8'(value), 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
